// File: rtl/uart_expr_parser.sv
// ASCII "<A><op><B><term>" expression parser sitting behind the UART byte receiver.
// Optional ESC abort is enabled by defining PARSER_ESC_EN.
module uart_expr_parser #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [1:0]       op_code,
  output logic             expr_valid,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for the first digit of A
  // OPA   | accumulating A, waiting for more digits or an operator
  // OPB0  | operator seen, waiting for the first digit of B
  // OPB   | accumulating B, waiting for more digits or a terminator
  // ERR   | discarding bytes until a terminator
  typedef enum logic [2:0] {IDLE, OPA, OPB0, OPB, ERR} state_t;

  localparam int EW = WIDTH + 4;
  localparam logic [1:0] ERR_SYNTAX   = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;

  state_t           state;
  logic [WIDTH-1:0] acc_a;
  logic [WIDTH-1:0] acc_b;
  logic [1:0]       op_lat;

  logic          is_digit;
  logic          is_op;
  logic          is_term;
  logic          is_space;
  logic [1:0]    op_enc;
  logic [EW-1:0] digit;
  logic [EW-1:0] next_a;
  logic [EW-1:0] next_b;
  logic          ovf_a;
  logic          ovf_b;
`ifdef PARSER_ESC_EN
  logic          is_esc;
`endif

  always_comb begin
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_term  = (rx_data == 8'h3D) || (rx_data == 8'h0D);
    is_space = (rx_data == 8'h20);
    is_op    = 1'b1;
    op_enc   = 2'b00;
    case (rx_data)
      8'h2B:   op_enc = 2'b00;
      8'h2D:   op_enc = 2'b01;
      8'h2A:   op_enc = 2'b10;
      8'h2F:   op_enc = 2'b11;
      default: is_op  = 1'b0;
    endcase
`ifdef PARSER_ESC_EN
    is_esc = (rx_data == 8'h1B);
`endif
    digit  = EW'(rx_data[3:0]);
    // Extra 4 bits hold acc*10+9 for any acc, so overflow is just the upper bits.
    next_a = {4'b0000, acc_a} * EW'(10) + digit;
    next_b = {4'b0000, acc_b} * EW'(10) + digit;
    ovf_a  = |next_a[EW-1:WIDTH];
    ovf_b  = |next_b[EW-1:WIDTH];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc_a      <= '0;
      acc_b      <= '0;
      op_lat     <= 2'b00;
      operand_a  <= '0;
      operand_b  <= '0;
      op_code    <= 2'b00;
      expr_valid <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      expr_valid <= 1'b0;
      err        <= 1'b0;
      if (rx_valid && !is_space) begin
`ifdef PARSER_ESC_EN
        if (is_esc) begin
          state <= IDLE;
          acc_a <= '0;
          acc_b <= '0;
        end else
`endif
        begin
          case (state)
            IDLE: begin
              if (is_digit) begin
                acc_a <= digit[WIDTH-1:0];
                state <= OPA;
              end else if (!is_term) begin
                err      <= 1'b1;
                err_code <= ERR_SYNTAX;
                state    <= ERR;
              end
            end
            OPA: begin
              if (is_digit) begin
                if (ovf_a) begin
                  err      <= 1'b1;
                  err_code <= ERR_OVERFLOW;
                  state    <= ERR;
                end else begin
                  acc_a <= next_a[WIDTH-1:0];
                end
              end else if (is_op) begin
                op_lat <= op_enc;
                acc_b  <= '0;
                state  <= OPB0;
              end else begin
                err      <= 1'b1;
                err_code <= ERR_SYNTAX;
                state    <= ERR;
              end
            end
            OPB0: begin
              if (is_digit) begin
                acc_b <= digit[WIDTH-1:0];
                state <= OPB;
              end else begin
                err      <= 1'b1;
                err_code <= ERR_SYNTAX;
                state    <= ERR;
              end
            end
            OPB: begin
              if (is_digit) begin
                if (ovf_b) begin
                  err      <= 1'b1;
                  err_code <= ERR_OVERFLOW;
                  state    <= ERR;
                end else begin
                  acc_b <= next_b[WIDTH-1:0];
                end
              end else if (is_term) begin
                operand_a  <= acc_a;
                operand_b  <= acc_b;
                op_code    <= op_lat;
                expr_valid <= 1'b1;
                state      <= IDLE;
              end else begin
                err      <= 1'b1;
                err_code <= ERR_SYNTAX;
                state    <= ERR;
              end
            end
            ERR: begin
              if (is_term) state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_expr_parser.sv
// Directed bench for uart_expr_parser; define PARSER_ESC_EN to exercise the ESC abort.
module tb_uart_expr_parser;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [1:0]       op_code;
  logic             expr_valid;
  logic             err;
  logic [1:0]       err_code;
  logic             busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
  } res_t;

  res_t       evq[$];
  logic [1:0] erq[$];

  uart_expr_parser #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .op_code    (op_code),
    .expr_valid (expr_valid),
    .err        (err),
    .err_code   (err_code),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  // Each strobe is high for exactly one negedge, so this captures every pulse once.
  always @(negedge clk) begin
    if (!rst) begin
      if (expr_valid) evq.push_back('{a: operand_a, b: operand_b, op: op_code});
      if (err) erq.push_back(err_code);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns on the negedge after the byte was sampled: its strobes are visible now.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_b2b(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = s[i];
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q;
    evq.delete();
    erq.delete();
  endtask

  task automatic chk_result(input string tag, input int idx, input int a, input int b, input int op);
    if (evq.size() > idx) begin
      chk({tag, "_a"}, 32'(evq[idx].a), 32'(a));
      chk({tag, "_b"}, 32'(evq[idx].b), 32'(b));
      chk({tag, "_op"}, 32'(evq[idx].op), 32'(op));
    end
  endtask

  string b2b_str;

  initial begin
    idle(3);
    chk("rst_operand_a", 32'(operand_a), 0);
    chk("rst_operand_b", 32'(operand_b), 0);
    chk("rst_op_code", 32'(op_code), 0);
    chk("rst_expr_valid", 32'(expr_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    idle(2);

    // "12+34=" with latency check on '='
    clear_q();
    send_str("12+34");
    chk("t1_busy_mid", 32'(busy), 1);
    send_byte("=");
    chk("t1_ev_latency", 32'(expr_valid), 1);
    chk("t1_busy_done", 32'(busy), 0);
    idle(2);
    chk("t1_ev_count", 32'(evq.size()), 1);
    chk("t1_err_count", 32'(erq.size()), 0);
    chk_result("t1", 0, 12, 34, 0);

    // back-to-back: "65535*2" CR "7/0="
    clear_q();
    b2b_str = "65535*2 7/0=";
    b2b_str[7] = 8'h0D;
    send_b2b(b2b_str);
    idle(2);
    chk("t2_ev_count", 32'(evq.size()), 2);
    chk("t2_err_count", 32'(erq.size()), 0);
    chk_result("t2_first", 0, 65535, 2, 2);
    chk_result("t2_second", 1, 7, 0, 3);

    // overflow on the final '6' of 65536
    clear_q();
    send_str("6553");
    send_byte("6");
    chk("t3_err_latency", 32'(err), 1);
    chk("t3_err_code", 32'(err_code), 2);
    send_str("+1=");
    idle(2);
    chk("t3_busy_after", 32'(busy), 0);
    chk("t3_err_code_held", 32'(err_code), 2);
    chk("t3_ev_count", 32'(evq.size()), 0);
    chk("t3_err_count", 32'(erq.size()), 1);
    clear_q();
    send_str("3-1=");
    idle(2);
    chk("t3b_ev_count", 32'(evq.size()), 1);
    chk_result("t3b", 0, 3, 1, 1);

    // syntax errors
    clear_q();
    send_byte("+");
    chk("t4_plus_err", 32'(err), 1);
    chk("t4_plus_code", 32'(err_code), 1);
    send_str("5=");
    chk("t4_plus_busy", 32'(busy), 0);
    send_str("5+");
    send_byte("=");
    chk("t4_eq_err", 32'(err), 1);
    chk("t4_eq_code", 32'(err_code), 1);
    send_byte(8'h0D);
    chk("t4_eq_busy", 32'(busy), 0);
    send_byte("5");
    send_byte("x");
    chk("t4_x_err", 32'(err), 1);
    chk("t4_x_code", 32'(err_code), 1);
    send_str("3=");
    idle(2);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_ev_count", 32'(evq.size()), 0);
    chk("t4_err_count", 32'(erq.size()), 3);

    // spaces everywhere, then a bare terminator in IDLE
    clear_q();
    send_str("9 9 - 1 =");
    idle(2);
    chk("t5_ev_count", 32'(evq.size()), 1);
    chk_result("t5", 0, 99, 1, 1);
    clear_q();
    send_byte("=");
    chk("t5_bare_busy", 32'(busy), 0);
    idle(2);
    chk("t5_bare_ev", 32'(evq.size()), 0);
    chk("t5_bare_err", 32'(erq.size()), 0);

    // reset mid-expression with a coincident byte
    clear_q();
    send_str("12+");
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = "4";
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b0;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_expr_valid", 32'(expr_valid), 0);
    chk("t6_err", 32'(err), 0);
    chk("t6_err_code", 32'(err_code), 0);
    chk("t6_operand_a", 32'(operand_a), 0);
    idle(1);
    send_str("4*5=");
    idle(2);
    chk("t6_ev_count", 32'(evq.size()), 1);
    chk("t6_err_count", 32'(erq.size()), 0);
    chk_result("t6", 0, 4, 5, 2);

    // ESC handling
    clear_q();
    send_str("12+");
    send_byte(8'h1B);
`ifdef PARSER_ESC_EN
    chk("t7_esc_busy", 32'(busy), 0);
    chk("t7_esc_err", 32'(err), 0);
    send_str("6/3=");
    idle(2);
    chk("t7_ev_count", 32'(evq.size()), 1);
    chk("t7_err_count", 32'(erq.size()), 0);
    chk_result("t7", 0, 6, 3, 3);
`else
    chk("t7_esc_err", 32'(err), 1);
    chk("t7_esc_code", 32'(err_code), 1);
    send_str("6/3=");
    idle(2);
    chk("t7_busy", 32'(busy), 0);
    chk("t7_ev_count", 32'(evq.size()), 0);
    chk("t7_err_count", 32'(erq.size()), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
